// File: rtl/sodor_rand_instr_gen.sv
// Seeded random RV32I instruction source for sodor5 co-simulation.
// Offers OP-IMM/OP/LOAD/STORE words over a valid/ready handshake.
module sodor_rand_instr_gen #(
    parameter logic [31:0] SEED      = 32'd571,
    parameter logic [3:0]  MODE_MASK = 4'b0001,
    parameter logic [4:0]  REG_MASK  = 5'h1f,
    parameter int          MEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [1:0]  instr_class,
    output logic [31:0] issue_count
);

    localparam logic [31:0] TAPS      = 32'h80200003;
    localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [3:0]  MASK_EFF  = (MODE_MASK == 4'd0) ? 4'b0001 : MODE_MASK;
    localparam logic [9:0]  WORD_MASK = 10'(MEM_WORDS - 1);
    localparam logic [31:0] NOP       = 32'h00000013;

    typedef enum logic [1:0] {IDLE, GEN, OFFER} state_e;

    state_e      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [1:0]  cls_q, cls_d;
    logic [31:0] count_q, count_d;

    logic [31:0] lfsr_step;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3, ld_f3, st_f3;
    logic [11:0] imm, oi_imm, ld_off, st_off;
    logic [1:0]  cls_raw, gen_cls, ld_bsel, st_bsel;
    logic [9:0]  word_idx;
    logic [6:0]  funct7;
    logic [31:0] gen_word;

    // Decode the current LFSR state into the next candidate instruction
    always_comb begin
        lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'd0);
        rd        = lfsr_q[4:0] & REG_MASK;
        rs1       = lfsr_q[9:5] & REG_MASK;
        rs2       = lfsr_q[14:10] & REG_MASK;
        f3        = lfsr_q[17:15];
        imm       = lfsr_q[29:18];
        cls_raw   = lfsr_q[31:30];
        if (MASK_EFF[cls_raw])  gen_cls = cls_raw;
        else if (MASK_EFF[0])   gen_cls = 2'd0;
        else if (MASK_EFF[1])   gen_cls = 2'd1;
        else if (MASK_EFF[2])   gen_cls = 2'd2;
        else                    gen_cls = 2'd3;
        // shift-immediates only keep shamt (and the SRAI bit)
        oi_imm = imm;
        if (f3 == 3'd1) oi_imm = imm & 12'h01f;
        if (f3 == 3'd5) oi_imm = imm & 12'h41f;
        funct7 = (lfsr_q[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
        // loads/stores stay naturally aligned inside the dmem window
        ld_f3 = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? 3'd2 : f3;
        st_f3 = (lfsr_q[16:15] == 2'd3) ? 3'd2 : {1'b0, lfsr_q[16:15]};
        unique case (ld_f3[1:0])
            2'b00:   ld_bsel = lfsr_q[1:0];
            2'b01:   ld_bsel = {lfsr_q[1], 1'b0};
            default: ld_bsel = 2'b00;
        endcase
        unique case (st_f3[1:0])
            2'b00:   st_bsel = lfsr_q[1:0];
            2'b01:   st_bsel = {lfsr_q[1], 1'b0};
            default: st_bsel = 2'b00;
        endcase
        word_idx = imm[9:0] & WORD_MASK;
        ld_off   = {word_idx, ld_bsel};
        st_off   = {word_idx, st_bsel};
        unique case (gen_cls)
            2'd0: gen_word = {oi_imm, rs1, f3, rd, 7'h13};
            2'd1: gen_word = {funct7, rs2, rs1, f3, rd, 7'h33};
            2'd2: gen_word = {ld_off, 5'd0, ld_f3, rd, 7'h03};
            default: gen_word = {st_off[11:5], rs2, 5'd0, st_f3,
                                 st_off[4:0], 7'h23};
        endcase
    end

    // Next-state logic for the IDLE/GEN/OFFER handshake sequencer
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        cls_d   = cls_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                instr_d = NOP;
                cls_d   = 2'd0;
                if (en) begin
                    lfsr_d  = lfsr_step;
                    state_d = GEN;
                end
            end
            GEN: begin
                instr_d = gen_word;
                cls_d   = gen_cls;
                valid_d = 1'b1;
                state_d = OFFER;
            end
            OFFER: begin
                if (instr_ready) begin
                    count_d = count_q + 32'd1;
                    valid_d = 1'b0;
                    instr_d = NOP;
                    cls_d   = 2'd0;
                    if (en) begin
                        lfsr_d  = lfsr_step;
                        state_d = GEN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset overrides any pending offer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_INIT;
            valid_q <= 1'b0;
            instr_q <= NOP;
            cls_q   <= 2'd0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            cls_q   <= cls_d;
            count_q <= count_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_class = cls_q;
    assign issue_count = count_q;

endmodule

// File: tb/tb_sodor_rand_instr_gen.sv
// Bench for sodor_rand_instr_gen: several configurations run in lockstep
// against a transaction-level reference of the instruction stream.
module tb_sodor_rand_instr_gen;

    localparam int N = 5;

    function automatic logic [31:0] p_seed(int i);
        case (i)
            0, 1:    return 32'd571;
            2:       return 32'hdeadbeef;
            3:       return 32'd0;
            default: return 32'd7;
        endcase
    endfunction

    function automatic logic [3:0] p_mode(int i);
        case (i)
            0, 1:    return 4'b0001;
            2:       return 4'b1100;
            3:       return 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [4:0] p_reg(int i);
        case (i)
            1:       return 5'h00;
            3:       return 5'h0f;
            default: return 5'h1f;
        endcase
    endfunction

    function automatic int p_mem(int i);
        case (i)
            3:       return 1024;
            4:       return 1;
            default: return 16;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset, en, ready;
    logic        v_w   [N];
    logic [31:0] ins_w [N];
    logic [1:0]  cls_w [N];
    logic [31:0] cnt_w [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sodor_rand_instr_gen #(
            .SEED     (p_seed(g)),
            .MODE_MASK(p_mode(g)),
            .REG_MASK (p_reg(g)),
            .MEM_WORDS(p_mem(g))
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .en         (en),
            .instr_ready(ready),
            .instr_valid(v_w[g]),
            .instr      (ins_w[g]),
            .instr_class(cls_w[g]),
            .issue_count(cnt_w[g])
        );
    end

    int nchk = 0;
    int nerr = 0;

    // reference: next LFSR value
    function automatic logic [31:0] adv(logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    // reference: {class, word} generated from post-advance state s
    function automatic logic [33:0] ref_gen(logic [31:0] s, int i);
        int unsigned cls, rd, rs1, rs2, f3, imm, off, sz, bsel, f7;
        logic [3:0]  m;
        logic [31:0] w;
        m   = (p_mode(i) == 4'd0) ? 4'b0001 : p_mode(i);
        cls = 32'(s[31:30]);
        if (!m[cls])
            for (int c = 3; c >= 0; c--)
                if (m[c]) cls = c;
        rd  = 32'(s[4:0] & p_reg(i));
        rs1 = 32'(s[9:5] & p_reg(i));
        rs2 = 32'(s[14:10] & p_reg(i));
        f3  = 32'(s[17:15]);
        imm = 32'(s[29:18]);
        case (cls)
            0: begin
                if (f3 == 1) imm = imm % 32;
                else if (f3 == 5) imm = (imm & 1024) + imm % 32;
                w = (imm << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
            end
            1: begin
                f7 = (s[30] && (f3 == 0 || f3 == 5)) ? 32 : 0;
                w = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
                  + (rd << 7) + 'h33;
            end
            2: begin
                if (f3 == 3 || f3 >= 6) f3 = 2;
                sz   = 1 << (f3 % 4);
                bsel = s % 4 - (s % 4) % sz;
                off  = (imm % p_mem(i)) * 4 + bsel;
                w = (off << 20) + (f3 << 12) + (rd << 7) + 'h03;
            end
            default: begin
                f3 = 32'(s[16:15]);
                if (f3 == 3) f3 = 2;
                sz   = 1 << f3;
                bsel = s % 4 - (s % 4) % sz;
                off  = (imm % p_mem(i)) * 4 + bsel;
                w = ((off / 32) << 25) + (rs2 << 20) + (f3 << 12)
                  + ((off % 32) << 7) + 'h23;
            end
        endcase
        return {2'(cls), w};
    endfunction

    // per-instance expected interface state
    logic [31:0] m_lfsr [N];
    int          m_ph   [N];
    logic        m_valid[N];
    logic [31:0] m_word [N];
    logic [1:0]  m_cls  [N];
    logic [31:0] m_cnt  [N];

    // one clock: advance the reference with the applied inputs
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_lfsr[i]  = (p_seed(i) == 0) ? 32'd1 : p_seed(i);
                m_ph[i]    = 0;
                m_valid[i] = 1'b0;
                m_word[i]  = 32'h13;
                m_cls[i]   = 2'd0;
                m_cnt[i]   = 32'd0;
            end else if (m_ph[i] == 0) begin
                if (en) begin
                    m_lfsr[i] = adv(m_lfsr[i]);
                    m_ph[i]   = 1;
                end
            end else if (m_ph[i] == 1) begin
                {m_cls[i], m_word[i]} = ref_gen(m_lfsr[i], i);
                m_valid[i] = 1'b1;
                m_ph[i]    = 2;
            end else if (ready) begin
                m_cnt[i]   = m_cnt[i] + 1;
                m_valid[i] = 1'b0;
                m_word[i]  = 32'h13;
                if (en) begin
                    m_lfsr[i] = adv(m_lfsr[i]);
                    m_ph[i]   = 1;
                end else begin
                    m_ph[i] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; ready = 1'b0;
        repeat (3) begin
            tick();
            for (int i = 0; i < N; i++) begin
                nchk++;
                if (v_w[i] !== 1'b0 || ins_w[i] !== 32'h13 ||
                    cls_w[i] !== 2'd0 || cnt_w[i] !== 32'd0) begin
                    nerr++;
                    $display("FAIL reset inst%0d: got v=%0b i=%h c=%0d n=%0d, exp 0/00000013/0/0",
                             i, v_w[i], ins_w[i], cls_w[i], cnt_w[i]);
                end
            end
        end
        reset = 1'b0;
        tick();
        for (int i = 0; i < N; i++) begin
            nchk++;
            if (v_w[i] !== 1'b0) begin
                nerr++;
                $display("FAIL latency1 inst%0d: got v=%0b exp 0", i, v_w[i]);
            end
        end
        tick();
        for (int i = 0; i < N; i++) begin
            nchk++;
            if (v_w[i] !== 1'b1 || ins_w[i] !== m_word[i] ||
                cls_w[i] !== m_cls[i]) begin
                nerr++;
                $display("FAIL latency2 inst%0d: got v=%0b i=%h c=%0d, exp 1 i=%h c=%0d",
                         i, v_w[i], ins_w[i], cls_w[i], m_word[i], m_cls[i]);
            end
        end
    endtask

    task automatic test_opimm_regmask();
        int cyc = 0;
        en = 1'b1; ready = 1'b1;
        while (m_cnt[1] < 200 && cyc < 1000) begin
            tick();
            cyc++;
            for (int i = 0; i < N; i++) begin
                nchk++;
                if (v_w[i] !== m_valid[i] || ins_w[i] !== m_word[i] ||
                    cnt_w[i] !== m_cnt[i] ||
                    (m_valid[i] && cls_w[i] !== m_cls[i])) begin
                    nerr++;
                    $display("FAIL opimm inst%0d: got v=%0b i=%h c=%0d n=%0d, exp v=%0b i=%h c=%0d n=%0d",
                             i, v_w[i], ins_w[i], cls_w[i], cnt_w[i],
                             m_valid[i], m_word[i], m_cls[i], m_cnt[i]);
                end
            end
            if (v_w[1]) begin
                nchk++;
                if (ins_w[1][6:0] !== 7'h13 || ins_w[1][11:7] !== 5'd0 ||
                    ins_w[1][19:15] !== 5'd0 ||
                    (ins_w[1][14:12] == 3'd1 && ins_w[1][31:25] !== 7'd0) ||
                    (ins_w[1][14:12] == 3'd5 &&
                     (ins_w[1][31:20] & 12'hbe0) !== 12'd0)) begin
                    nerr++;
                    $display("FAIL opimm_fields: got i=%h exp OP-IMM x0 legal shamt",
                             ins_w[1]);
                end
            end
        end
        nchk++;
        if (cnt_w[1] !== 32'd200) begin
            nerr++;
            $display("FAIL opimm_count: got %0d exp 200", cnt_w[1]);
        end
    endtask

    task automatic test_stall();
        int          cyc = 0;
        logic [31:0] c0;
        en = 1'b1; ready = 1'b0;
        while (!m_valid[0] && cyc < 5) begin
            tick();
            cyc++;
        end
        c0 = m_cnt[0];
        repeat (5) begin
            en = 1'($urandom_range(0, 1));
            tick();
            for (int i = 0; i < N; i++) begin
                nchk++;
                if (v_w[i] !== 1'b1 || ins_w[i] !== m_word[i] ||
                    cls_w[i] !== m_cls[i] || cnt_w[i] !== m_cnt[i]) begin
                    nerr++;
                    $display("FAIL stall inst%0d: got v=%0b i=%h c=%0d n=%0d, exp v=1 i=%h c=%0d n=%0d",
                             i, v_w[i], ins_w[i], cls_w[i], cnt_w[i],
                             m_word[i], m_cls[i], m_cnt[i]);
                end
            end
        end
        en = 1'b1; ready = 1'b1;
        tick();
        nchk++;
        if (cnt_w[0] !== c0 + 32'd1 || v_w[0] !== 1'b0) begin
            nerr++;
            $display("FAIL stall_release: got n=%0d v=%0b exp n=%0d v=0",
                     cnt_w[0], v_w[0], c0 + 32'd1);
        end
        ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            nchk++;
            if (v_w[i] !== 1'b1 || ins_w[i] !== m_word[i]) begin
                nerr++;
                $display("FAIL stall_next inst%0d: got v=%0b i=%h exp v=1 i=%h",
                         i, v_w[i], ins_w[i], m_word[i]);
            end
        end
    endtask

    task automatic test_mem_classes();
        logic [11:0] off;
        logic [2:0]  f3;
        repeat (400) begin
            en    = ($urandom_range(0, 7) != 0);
            ready = 1'($urandom_range(0, 1));
            tick();
            for (int i = 0; i < N; i++) begin
                nchk++;
                if (v_w[i] !== m_valid[i] || ins_w[i] !== m_word[i] ||
                    cnt_w[i] !== m_cnt[i] ||
                    (m_valid[i] && cls_w[i] !== m_cls[i])) begin
                    nerr++;
                    $display("FAIL mem inst%0d: got v=%0b i=%h c=%0d n=%0d, exp v=%0b i=%h c=%0d n=%0d",
                             i, v_w[i], ins_w[i], cls_w[i], cnt_w[i],
                             m_valid[i], m_word[i], m_cls[i], m_cnt[i]);
                end
            end
            if (v_w[2]) begin
                f3  = ins_w[2][14:12];
                off = (ins_w[2][6:0] == 7'h03) ? ins_w[2][31:20]
                                               : {ins_w[2][31:25], ins_w[2][11:7]};
                nchk++;
                if (!(ins_w[2][6:0] == 7'h03 || ins_w[2][6:0] == 7'h23) ||
                    ins_w[2][19:15] !== 5'd0 || off >= 12'd64 ||
                    (f3[1:0] == 2'd2 && off[1:0] != 2'd0) ||
                    (f3[1:0] == 2'd1 && off[0] != 1'b0) ||
                    f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 ||
                    (ins_w[2][6:0] == 7'h23 && f3 > 3'd2)) begin
                    nerr++;
                    $display("FAIL mem_fields: got i=%h off=%0d exp aligned ld/st x0 off<64",
                             ins_w[2], off);
                end
            end
        end
    endtask

    task automatic test_reset_mid_offer();
        logic [31:0] got[$];
        logic [31:0] s, e;
        int          cyc = 0;
        en = 1'b1; ready = 1'b0;
        while (!m_valid[0] && cyc < 5) begin
            tick();
            cyc++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            nchk++;
            if (v_w[i] !== 1'b0 || ins_w[i] !== 32'h13 || cnt_w[i] !== 32'd0) begin
                nerr++;
                $display("FAIL midreset inst%0d: got v=%0b i=%h n=%0d exp 0/00000013/0",
                         i, v_w[i], ins_w[i], cnt_w[i]);
            end
        end
        cyc = 0;
        while (got.size() < 100 && cyc < 1000) begin
            ready = 1'($urandom_range(0, 1));
            if (ready && v_w[0]) got.push_back(ins_w[0]);
            tick();
            cyc++;
        end
        nchk++;
        if (got.size() != 100 || cnt_w[0] !== 32'd100) begin
            nerr++;
            $display("FAIL rerun_count: got %0d words n=%0d exp 100/100",
                     got.size(), cnt_w[0]);
        end
        s = p_seed(0);
        for (int k = 0; k < got.size(); k++) begin
            s = adv(s);
            e = ref_gen(s, 0)[31:0];
            nchk++;
            if (got[k] !== e) begin
                nerr++;
                $display("FAIL rerun_seq[%0d]: got %h exp %h", k, got[k], e);
            end
        end
    endtask

    task automatic test_en_drop();
        int cyc = 0;
        en = 1'b1; ready = 1'b0;
        while (!m_valid[0] && cyc < 5) begin
            tick();
            cyc++;
        end
        en = 1'b0;
        repeat (3) begin
            tick();
            nchk++;
            if (v_w[0] !== 1'b1 || ins_w[0] !== m_word[0]) begin
                nerr++;
                $display("FAIL endrop_hold: got v=%0b i=%h exp v=1 i=%h",
                         v_w[0], ins_w[0], m_word[0]);
            end
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        nchk++;
        if (v_w[0] !== 1'b0 || ins_w[0] !== 32'h13) begin
            nerr++;
            $display("FAIL endrop_idle: got v=%0b i=%h exp v=0 i=00000013",
                     v_w[0], ins_w[0]);
        end
        repeat (6) tick();
        en = 1'b1; ready = 1'b1;
        repeat (12) begin
            tick();
            for (int i = 0; i < N; i++) begin
                nchk++;
                if (v_w[i] !== m_valid[i] || ins_w[i] !== m_word[i] ||
                    cnt_w[i] !== m_cnt[i]) begin
                    nerr++;
                    $display("FAIL endrop_resume inst%0d: got v=%0b i=%h n=%0d, exp v=%0b i=%h n=%0d",
                             i, v_w[i], ins_w[i], cnt_w[i],
                             m_valid[i], m_word[i], m_cnt[i]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_opimm_regmask();
        test_stall();
        test_mem_classes();
        test_reset_mid_offer();
        test_en_drop();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
